systolic_array_ctrl: RTL

Sequencer for an N×N output-stationary array of multiply-accumulate PEs. Each PE has load (hold), clear (zero) and carry_enable (pass neighbour's result) controls. On a start request this block:
- clears every accumulator,
- runs a skewed feed of K operand pairs, producing the step index and per-row/per-column valid masks for the operand feeders,
- drains the N result rows one per cycle through the carry chain,
- reports completion.

It sits between the host/DMA command interface and the PE grid.

---
 rtl/systolic_array_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl
// Sequencer for an N x N output-stationary MAC array. On start it clears the
// accumulators, runs a skewed feed of K operand pairs, drains the N result
// rows one per cycle through the carry chain and then pulses done.
//
// Ports
//   clock, reset_n       rising-edge clock, async active-low reset
//   start, k_len         begin an operation (sampled in IDLE), K length
//   abort                synchronous cancel, ignored in IDLE
//   busy, done           status: busy CLEAR..DRAIN, done one-cycle pulse
//   pe_clear, pe_load    broadcast PE clear / hold
//   pe_carry_enable[N]   per-row carry select
//   feed_step            compute-step index t
//   row_valid, col_valid per-row / per-column feeder valid masks
//   drain_valid          array output carries a result row
//   drain_row            index of the row on the array output
//   perf_cycles          busy-cycle counter, present only when
//                        SYSTOLIC_CTRL_PERF_EN is defined
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for start; PEs hold
//   S_CLEAR   | one cycle, zero every accumulator
//   S_COMPUTE | K+2N-2 skewed feed steps, t = 0 .. K+2N-3
//   S_DRAIN   | N cycles, row drain_row carried to the array output
//   S_DONE    | one-cycle completion pulse
module systolic_array_ctrl #(
   parameter int N  = 4,
   parameter int KW = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [KW-1:0]          k_len,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic                   pe_clear,
   output logic                   pe_load,
   output logic [N-1:0]           pe_carry_enable,
   output logic [KW+$clog2(N):0]  feed_step,
   output logic [N-1:0]           row_valid,
   output logic [N-1:0]           col_valid,
   output logic                   drain_valid,
   output logic [$clog2(N)-1:0]   drain_row
`ifdef SYSTOLIC_CTRL_PERF_EN
   ,
   output logic [31:0]            perf_cycles
`endif
);

   localparam int TW = KW + $clog2(N) + 1;
   localparam int LW = $clog2(N);
   localparam logic [TW-1:0] ONE          = TW'(1);
   localparam logic [TW-1:0] COMPUTE_TAIL = TW'(2*N - 3);
   localparam logic [TW-1:0] DRAIN_LAST   = TW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_COMPUTE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state, state_n;
   logic [KW-1:0] k_reg, k_reg_n;
   logic [TW-1:0] step, step_n;
   logic [TW-1:0] remain, remain_n;
   logic [TW-1:0] k_ext_n;

   logic          busy_n, done_n, clear_n, load_n, dv_n;
   logic [N-1:0]  carry_n, rv_n;
   logic [TW-1:0] feed_n;
   logic [LW-1:0] drow_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         k_reg  <= '0;
         step   <= '0;
         remain <= '0;
      end else begin
         state  <= state_n;
         k_reg  <= k_reg_n;
         step   <= step_n;
         remain <= remain_n;
      end
   end

   // remain is a down-counter of cycles left in the current phase; step is
   // the up-counting t (COMPUTE) or row index (DRAIN).
   always_comb begin
      state_n  = state;
      k_reg_n  = k_reg;
      step_n   = step;
      remain_n = remain;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_CLEAR;
               k_reg_n = k_len;
            end
         end
         S_CLEAR: begin
            step_n = '0;
            if (k_reg != '0) begin
               state_n  = S_COMPUTE;
               remain_n = {{(TW-KW){1'b0}}, k_reg} + COMPUTE_TAIL;
            end else begin
               state_n  = S_DRAIN;
               remain_n = DRAIN_LAST;
            end
         end
         S_COMPUTE: begin
            if (remain == '0) begin
               state_n  = S_DRAIN;
               step_n   = '0;
               remain_n = DRAIN_LAST;
            end else begin
               step_n   = step + ONE;
               remain_n = remain - ONE;
            end
         end
         S_DRAIN: begin
            if (remain == '0) begin
               state_n = S_DONE;
            end else begin
               step_n   = step + ONE;
               remain_n = remain - ONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) begin
         state_n = S_IDLE;
      end
   end

   // Outputs are decoded from the next state so that the registered values
   // line up with the state they describe.
   assign k_ext_n = {{(TW-KW){1'b0}}, k_reg_n};

   always_comb begin
      busy_n  = 1'b0;
      done_n  = 1'b0;
      clear_n = 1'b0;
      load_n  = 1'b1;
      dv_n    = 1'b0;
      carry_n = '0;
      rv_n    = '0;
      feed_n  = '0;
      drow_n  = '0;
      unique case (state_n)
         S_CLEAR: begin
            busy_n  = 1'b1;
            clear_n = 1'b1;
         end
         S_COMPUTE: begin
            busy_n = 1'b1;
            load_n = 1'b0;
            feed_n = step_n;
            for (int i = 0; i < N; i++) begin
               rv_n[i] = (step_n >= TW'(i)) && (step_n < (TW'(i) + k_ext_n));
            end
         end
         S_DRAIN: begin
            busy_n = 1'b1;
            dv_n   = 1'b1;
            drow_n = step_n[LW-1:0];
            for (int i = 0; i < N; i++) begin
               carry_n[i] = (step_n[LW-1:0] != LW'(i));
            end
         end
         S_DONE:  done_n = 1'b1;
         default: ;
      endcase
   end

   // Square array: the column skew is identical to the row skew.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy            <= 1'b0;
         done            <= 1'b0;
         pe_clear        <= 1'b0;
         pe_load         <= 1'b1;
         pe_carry_enable <= '0;
         feed_step       <= '0;
         row_valid       <= '0;
         col_valid       <= '0;
         drain_valid     <= 1'b0;
         drain_row       <= '0;
      end else begin
         busy            <= busy_n;
         done            <= done_n;
         pe_clear        <= clear_n;
         pe_load         <= load_n;
         pe_carry_enable <= carry_n;
         feed_step       <= feed_n;
         row_valid       <= rv_n;
         col_valid       <= rv_n;
         drain_valid     <= dv_n;
         drain_row       <= drow_n;
      end
   end

`ifdef SYSTOLIC_CTRL_PERF_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_cycles <= '0;
      end else if ((state == S_IDLE) && start) begin
         perf_cycles <= '0;
      end else if (busy) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule
